// File: rtl/fabosc_pkg.sv
`default_nettype none
// ============================================================================
// fabosc_pkg
// Default monitor constants and window-counter width helper.
// Revision: 1.0
// ============================================================================
package fabosc_pkg;

  localparam int DEF_WIN_CYCLES = 50000;
  localparam int DEF_MIN_EDGES  = 900;
  localparam int DEF_MAX_EDGES  = 1100;

  function automatic int win_cnt_w(input int win_cycles);
    return (win_cycles > 1) ? $clog2(win_cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fabosc_clken_ch.sv
`default_nettype none
// ============================================================================
// fabosc_clken_ch
// One clock-enable channel: shadow divisor, phase counter, pulse register.
// Revision: 1.0
// ============================================================================
module fabosc_clken_ch #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             clken
);

  logic [DIV_W-1:0] r_shadow;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clken;

  // A load restarts the phase and suppresses any pulse from the old divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_clken  <= 1'b0;
    end else if (load) begin
      r_shadow <= div_in;
      r_cnt    <= '0;
      r_clken  <= 1'b0;
    end else if (!en) begin
      r_cnt    <= '0;
      r_clken  <= 1'b0;
    end else if (r_cnt == r_shadow) begin
      r_cnt    <= '0;
      r_clken  <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + DIV_W'(1);
      r_clken  <= 1'b0;
    end
  end

  assign clken = r_clken;

endmodule
`default_nettype wire

// File: rtl/fabosc_clken_monitor.sv
`default_nettype none
// ============================================================================
// fabosc_clken_monitor
// Programmable clock-enable generator plus windowed frequency monitor.
// Revision: 1.0
// ============================================================================
module fabosc_clken_monitor
  import fabosc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 16,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES,
  parameter int CNT_W      = 16,
  parameter int MIN_EDGES  = DEF_MIN_EDGES,
  parameter int MAX_EDGES  = DEF_MAX_EDGES
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       CH_EN,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VALUE,
  input  logic                    DIV_LOAD,
  output logic [NUM_CH-1:0]       CLKEN_OUT,
  input  logic                    MON_CLK,
  input  logic                    MON_CLR,
  output logic [CNT_W-1:0]        MON_COUNT,
  output logic                    MON_VALID,
  output logic                    MON_OK,
  output logic                    MON_FAIL_STICKY
);

  localparam int               WIN_W      = win_cnt_w(WIN_CYCLES);
  localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_EDGES);
  localparam logic [CNT_W-1:0] C_SAT      = '1;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      fabosc_clken_ch #(
        .DIV_W (DIV_W)
      ) u_ch (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .en     (CH_EN[gi]),
        .load   (DIV_LOAD),
        .div_in (DIV_VALUE[gi*DIV_W +: DIV_W]),
        .clken  (CLKEN_OUT[gi])
      );
    end
  endgenerate

  logic [2:0]       r_mon_sync;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_mon_count;
  logic             r_mon_valid;
  logic             r_mon_ok;
  logic             r_mon_sticky;

  logic             w_edge_det;
  logic             w_terminal;
  logic [CNT_W-1:0] w_edge_next;
  logic             w_in_range;

  // Two flops resynchronise MON_CLK; the third holds the previous level.
  assign w_edge_det  = r_mon_sync[1] & ~r_mon_sync[2];
  assign w_terminal  = (r_win_cnt == C_WIN_LAST);
  assign w_edge_next = (w_edge_det && (r_edge_cnt != C_SAT)) ? r_edge_cnt + CNT_W'(1)
                                                             : r_edge_cnt;
  assign w_in_range  = (w_edge_next >= C_MIN) && (w_edge_next <= C_MAX);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mon_sync   <= '0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_mon_count  <= '0;
      r_mon_valid  <= 1'b0;
      r_mon_ok     <= 1'b0;
      r_mon_sticky <= 1'b0;
    end else begin
      r_mon_sync <= {r_mon_sync[1:0], MON_CLK};
      if (w_terminal) begin
        r_win_cnt   <= '0;
        r_edge_cnt  <= '0;
        r_mon_count <= w_edge_next;
        r_mon_valid <= 1'b1;
        r_mon_ok    <= w_in_range;
      end else begin
        r_win_cnt   <= r_win_cnt + WIN_W'(1);
        r_edge_cnt  <= w_edge_next;
      end
      // A failing window outranks a simultaneous clear.
      if (w_terminal && !w_in_range) begin
        r_mon_sticky <= 1'b1;
      end else if (MON_CLR) begin
        r_mon_sticky <= 1'b0;
      end
    end
  end

  assign MON_COUNT       = r_mon_count;
  assign MON_VALID       = r_mon_valid;
  assign MON_OK          = r_mon_ok;
  assign MON_FAIL_STICKY = r_mon_sticky;

endmodule
`default_nettype wire

// File: tb/tb_fabosc_clken_monitor.sv
`default_nettype none
// ============================================================================
// tb_fabosc_clken_monitor
// Directed and randomized checks against a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_fabosc_clken_monitor;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int WIN    = 100;
  localparam int CNT_W  = 8;
  localparam int MINE   = 8;
  localparam int MAXE   = 12;

  logic                    CLK = 1'b0;
  logic                    RESET_N;
  logic [NUM_CH-1:0]       CH_EN;
  logic [NUM_CH*DIV_W-1:0] DIV_VALUE;
  logic                    DIV_LOAD;
  logic [NUM_CH-1:0]       CLKEN_OUT;
  logic                    MON_CLK;
  logic                    MON_CLR;
  logic [CNT_W-1:0]        MON_COUNT;
  logic                    MON_VALID;
  logic                    MON_OK;
  logic                    MON_FAIL_STICKY;

  always #5 CLK = ~CLK;

  fabosc_clken_monitor #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .WIN_CYCLES (WIN),
    .CNT_W      (CNT_W),
    .MIN_EDGES  (MINE),
    .MAX_EDGES  (MAXE)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .CH_EN           (CH_EN),
    .DIV_VALUE       (DIV_VALUE),
    .DIV_LOAD        (DIV_LOAD),
    .CLKEN_OUT       (CLKEN_OUT),
    .MON_CLK         (MON_CLK),
    .MON_CLR         (MON_CLR),
    .MON_COUNT       (MON_COUNT),
    .MON_VALID       (MON_VALID),
    .MON_OK          (MON_OK),
    .MON_FAIL_STICKY (MON_FAIL_STICKY)
  );

  // Reference model state: edges since reset, per-channel run length,
  // and the clock edges at which each monitored rise becomes countable.
  int                n;
  int                shadow [NUM_CH];
  int                run    [NUM_CH];
  logic [NUM_CH-1:0] exp_clken;
  int                pend [$];
  logic              prev_mon;
  int                acc;
  int                exp_count;
  logic              exp_valid, exp_ok, exp_sticky;
  int                mon_per, mon_ph;
  int                passes, fails, total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_all();
    check("clken",  32'(CLKEN_OUT),       32'(exp_clken));
    check("count",  32'(MON_COUNT),       32'(exp_count));
    check("valid",  32'(MON_VALID),       32'(exp_valid));
    check("ok",     32'(MON_OK),          32'(exp_ok));
    check("sticky", 32'(MON_FAIL_STICKY), 32'(exp_sticky));
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow[i] = 0;
      run[i]    = 0;
    end
    exp_clken  = '0;
    pend.delete();
    prev_mon   = 1'b0;
    acc        = 0;
    exp_count  = 0;
    exp_valid  = 1'b0;
    exp_ok     = 1'b0;
    exp_sticky = 1'b0;
  endtask

  task automatic model_edge();
    n++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (DIV_LOAD) begin
        shadow[i]    = int'(DIV_VALUE[i*DIV_W +: DIV_W]);
        run[i]       = 0;
        exp_clken[i] = 1'b0;
      end else if (!CH_EN[i]) begin
        run[i]       = 0;
        exp_clken[i] = 1'b0;
      end else begin
        run[i]++;
        exp_clken[i] = ((run[i] % (shadow[i] + 1)) == 0);
      end
    end
    // A rise sampled at edge k is counted at edge k+2.
    if (MON_CLK && !prev_mon) pend.push_back(n + 2);
    prev_mon = MON_CLK;
    while (pend.size() > 0 && pend[0] == n) begin
      void'(pend.pop_front());
      acc++;
    end
    if (n % WIN == 0) begin
      exp_count = (acc > 255) ? 255 : acc;
      acc       = 0;
      exp_valid = 1'b1;
      exp_ok    = (exp_count >= MINE) && (exp_count <= MAXE);
      if (!exp_ok) exp_sticky = 1'b1;
      else if (MON_CLR) exp_sticky = 1'b0;
    end else if (MON_CLR) begin
      exp_sticky = 1'b0;
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] en, input logic load, input logic clr);
    @(negedge CLK);
    CH_EN    = en;
    DIV_LOAD = load;
    MON_CLR  = clr;
    if (mon_per >= 2) begin
      MON_CLK = (mon_ph < mon_per / 2);
      mon_ph  = (mon_ph + 1) % mon_per;
    end else begin
      MON_CLK = 1'b0;
    end
    @(posedge CLK);
    model_edge();
    #1 check_all();
  endtask

  task automatic run_n(input int k, input logic [NUM_CH-1:0] en);
    for (int j = 0; j < k; j++) step(en, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
  endtask

  initial begin
    passes = 0; fails = 0; total = 0;
    mon_per = 10; mon_ph = 0;
    RESET_N = 1'b0; CH_EN = '0; DIV_VALUE = '0; DIV_LOAD = 1'b0;
    MON_CLK = 1'b0; MON_CLR = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;

    // Divisor load {3,0,9,1} with all channels enabled
    DIV_VALUE = {16'd3, 16'd0, 16'd9, 16'd1};
    step(4'hF, 1'b1, 1'b0);
    run_n(40, 4'hF);

    // Reload ch3 to 7 when its counter reaches 2, then drop CH_EN[3]
    step(4'hF, 1'b1, 1'b0);
    run_n(2, 4'hF);
    DIV_VALUE = {16'd7, 16'd0, 16'd9, 16'd1};
    step(4'hF, 1'b1, 1'b0);
    run_n(20, 4'hF);
    run_n(5, 4'h7);

    // In-range monitor: period 10 over two full windows
    while (n < 2 * WIN + 5) step(4'hF, 1'b0, 1'b0);

    // Out-of-range at period 5, then back to 10 with a clear
    mon_per = 5; mon_ph = 0;
    while (n < 4 * WIN + 5) step(4'hF, 1'b0, 1'b0);
    mon_per = 10; mon_ph = 0;
    while (n < 5 * WIN + 10) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    while (n < 7 * WIN + 5) step(4'hF, 1'b0, 1'b0);

    // Clear on a non-terminal cycle, then collide clear with a failing window end
    mon_per = 5; mon_ph = 0;
    while (n < 8 * WIN + 5) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    while ((n + 1) % WIN != 0) step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b1);
    run_n(3, 4'hF);

    // Stuck-low monitored clock
    mon_per = 0;
    while (n < 11 * WIN + 5) step(4'hF, 1'b0, 1'b0);

    // Randomized periods, enables, reloads and clears
    for (int w = 0; w < 10; w++) begin
      mon_per = int'($urandom_range(6, 14));
      for (int j = 0; j < WIN; j++) begin
        logic [NUM_CH-1:0] en_r;
        logic ld, cl;
        en_r = ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : CH_EN;
        ld   = ($urandom_range(0, 39) == 0);
        cl   = ($urandom_range(0, 24) == 0);
        if (ld) begin
          for (int i = 0; i < NUM_CH; i++)
            DIV_VALUE[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
        end
        step(en_r, ld, cl);
      end
    end

    // Asynchronous reset mid-window with pulses active
    mon_per = 10; mon_ph = 0;
    DIV_VALUE = {16'd3, 16'd0, 16'd9, 16'd1};
    step(4'hF, 1'b1, 1'b0);
    run_n(37, 4'hF);
    async_reset();
    run_n(WIN + 20, 4'hF);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
